m_ext_muldiv_ctrl: RTL
======================

Name: m_ext_muldiv_ctrl

Overview:
Sequencing controller and datapath for the RV32M extension: one 32x32 multiplier and one iterative restoring divider, shared by all eight RV32M funct3 operations.
- Sits in the execute stage, beside the ALU.
- The decoder asserts a request only for opcode 0110011 with funct7 0000001.
- The block owns the multi-cycle FSM, the special-case handling and the valid/ready handshakes to the pipeline.

Parameters:
XLEN, 32, operand width; only 32 is supported, and any other value is an elaboration error.
DIV_BITS_PER_CYCLE, 1, quotient bits resolved per divide cycle; legal values 1, 2, 4.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
flush  in  1  pipeline flush; aborts the current operation
req_valid  in  1  request valid
req_ready  out  1  unit can accept a request
funct3  in  3  RV32M operation code (MUL..REMU)
rs1  in  XLEN  operand 1
rs2  in  XLEN  operand 2
resp_valid  out  1  result valid
resp_ready  in  1  consumer accepts result
result  out  XLEN  result value
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, result=0, busy=0, iteration counter=0.
- States:
  - IDLE: req_ready=1. On accept (req_valid&&req_ready), latch funct3, rs1 and rs2.
  - MUL: compute the 64-bit product into a register.
  - DIV: iterate the divider.
  - DONE: resp_valid=1; result is held stable until resp_ready.
- Transitions out of IDLE on accept:
  - MUL/MULH/MULHSU/MULHU -> MUL.
  - DIV family with rs2==0, or signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM) -> DONE directly.
  - Any other DIV family -> DIV, counter loaded with 32/DIV_BITS_PER_CYCLE-1.
- MUL -> DONE after 1 cycle.
- DIV -> DONE when counter==0 at the end of an iteration; the sign fixup is applied on the same edge.
- DONE -> IDLE when resp_ready. There is no same-cycle re-accept: req_ready=0 in DONE.
- Latency (accept edge to resp_valid high):
  - MUL family: 2 cycles.
  - Divide special cases: 1 cycle.
  - Normal divide: 32/DIV_BITS_PER_CYCLE + 1 cycles (33 at default).
- Multiply:
  - Operands extend to 33 bits: signed for rs1 on MULH/MULHSU, and for rs2 on MULH only.
  - MUL returns product[31:0]; the others return product[63:32].
- Divide:
  - Signed ops divide magnitudes.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of rs1.
- Special-case results:
  - Divide by zero: quotient=0xFFFFFFFF, remainder=rs1.
  - Overflow: quotient=0x80000000, remainder=0.
- flush: highest priority after reset. Next edge forces IDLE and resp_valid=0, discarding any in-flight or unconsumed result. A req_valid in the same cycle as flush is ignored.
- Reset mid-operation: identical to flush, plus all registers return to their reset values.
- resp_valid&&!resp_ready: stall in DONE indefinitely; result is unchanged.

Optional Feature:
Macro M_DIV_REM_FUSE_EN.
- Defined:
  - The unit retains rs1, rs2, signedness, quotient and remainder of the last completed normal divide, plus a valid bit.
  - A DIV/REM (or DIVU/REMU) request with identical operands and signedness goes IDLE->DONE with 1-cycle latency.
  - flush and reset clear the valid bit.
  - A special-case divide does not update the retained values.
- Undefined: no retained state; every divide takes full latency.

Decomposition:
- Shared package (the existing M-extension package): RV32M funct3 localparams, an enum typedef for the FSM states, and a packed struct for the latched request (funct3, rs1, rs2, is_signed, is_rem).
- One sub-module, m_div_step: combinational restoring step for DIV_BITS_PER_CYCLE bits (partial remainder, divisor, quotient in -> out). It is instantiated once inside the controller.

Test Plan:
- MULH rs1=0x80000000 rs2=0x80000000 -> result 0x40000000, resp_valid 2 cycles after accept. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF. MUL 7*-3 -> 0xFFFFFFEB.
- DIV rs1=0xFFFFFFF9 (-7) rs2=2 -> 0xFFFFFFFD after 33 cycles. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF. REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same -> 0. Each with 1-cycle latency.
- Hold resp_ready=0 for 10 cycles in DONE -> result stable, req_ready=0. Then pulse resp_ready -> IDLE next cycle with req_ready=1.
- Assert flush at divide iteration 10 -> next cycle IDLE, no resp_valid ever for that request. Next DIVU 9/3 -> 3 at normal latency. Repeat the sequence using rst_n low instead of flush -> all outputs at their reset values.
- With M_DIV_REM_FUSE_EN: DIV 100/7, then REM 100/7 -> second result 2 with 1-cycle latency. Insert a flush between the two -> REM takes 33 cycles.

Source files
------------

// File: rtl/m_ext_muldiv_pkg.sv
// Shared RV32M definitions: funct3 codes, controller FSM states and latched request payload.
package m_ext_muldiv_pkg;

  localparam int unsigned RV_XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } muldiv_state_e;

  typedef struct packed {
    logic [2:0]         funct3;
    logic [RV_XLEN-1:0] rs1;
    logic [RV_XLEN-1:0] rs2;
    logic               is_signed;
    logic               is_rem;
  } muldiv_req_t;

  // Two's-complement magnitude when the operand is treated as signed.
  function automatic logic [RV_XLEN-1:0] mag(input logic [RV_XLEN-1:0] v, input logic sgn);
    return (sgn && v[RV_XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/m_div_step.sv
// Combinational restoring-divide step resolving BITS quotient bits per call.
module m_div_step #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned BITS = 1
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  // quo carries the unconsumed dividend bits at the top and new quotient bits at the bottom.
  always_comb begin
    logic [XLEN:0] trial;
    rem_o = rem_i;
    quo_o = quo_i;
    trial = '0;
    for (int unsigned i = 0; i < BITS; i++) begin
      trial = {rem_o, quo_o[XLEN-1]};
      if (trial >= {1'b0, dvs_i}) begin
        trial = trial - {1'b0, dvs_i};
        quo_o = {quo_o[XLEN-2:0], 1'b1};
      end else begin
        quo_o = {quo_o[XLEN-2:0], 1'b0};
      end
      rem_o = trial[XLEN-1:0];
    end
  end

endmodule

// File: rtl/m_ext_muldiv_ctrl.sv
// RV32M sequencing controller: single-cycle multiplier plus iterative restoring divider.
// Optional macro M_DIV_REM_FUSE_EN retains the last normal divide for a fast DIV/REM pair.
module m_ext_muldiv_ctrl
  import m_ext_muldiv_pkg::*;
#(
  parameter int unsigned XLEN               = 32,
  parameter int unsigned DIV_BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned N_ITER = XLEN / DIV_BITS_PER_CYCLE;
  localparam int unsigned CNT_W  = $clog2(N_ITER);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N_ITER - 1);

  if (XLEN != 32) begin : g_xlen_chk
    $error("m_ext_muldiv_ctrl: only XLEN=32 is supported");
  end
  if (DIV_BITS_PER_CYCLE != 1 && DIV_BITS_PER_CYCLE != 2 && DIV_BITS_PER_CYCLE != 4) begin : g_step_chk
    $error("m_ext_muldiv_ctrl: DIV_BITS_PER_CYCLE must be 1, 2 or 4");
  end

  muldiv_state_e   state_q, state_d;
  muldiv_req_t     req_q, req_d, in_req;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic            busy_q, busy_d;

  logic            accept, in_div, in_signed, in_rem, in_div0, in_ovf;
  logic            fuse_hit;
  logic [XLEN-1:0] fuse_res;
  logic [XLEN-1:0] step_rem, step_quo;
  logic [XLEN-1:0] quo_fix, rem_fix, div_res, mul_res;
  logic [32:0]     mul_a, mul_b;
  logic [63:0]     prod;

  // Request decode straight from the pipeline inputs for the accept cycle.
  always_comb begin
    accept           = req_valid && req_ready_q;
    in_div           = funct3[2];
    in_signed        = in_div && !funct3[0];
    in_rem           = in_div && funct3[1];
    in_div0          = (rs2 == '0);
    in_ovf           = in_signed && (rs1 == 32'h8000_0000) && (rs2 == '1);
    in_req.funct3    = funct3;
    in_req.rs1       = rs1;
    in_req.rs2       = rs2;
    in_req.is_signed = in_signed;
    in_req.is_rem    = in_rem;
  end

  // Multiply from latched operands, sign-extended to 33 bits as the op demands.
  always_comb begin
    mul_a   = {(req_q.funct3 == F3_MULH || req_q.funct3 == F3_MULHSU) && req_q.rs1[31], req_q.rs1};
    mul_b   = {(req_q.funct3 == F3_MULH) && req_q.rs2[31], req_q.rs2};
    prod    = 64'($signed(mul_a)) * 64'($signed(mul_b));
    mul_res = (req_q.funct3 == F3_MUL) ? prod[31:0] : prod[63:32];
  end

  m_div_step #(
    .XLEN (XLEN),
    .BITS (DIV_BITS_PER_CYCLE)
  ) u_div_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Sign fixup applied to the final step output on the DIV->DONE edge.
  always_comb begin
    quo_fix = (req_q.is_signed && (req_q.rs1[31] ^ req_q.rs2[31])) ? -step_quo : step_quo;
    rem_fix = (req_q.is_signed && req_q.rs1[31]) ? -step_rem : step_rem;
    div_res = req_q.is_rem ? rem_fix : quo_fix;
  end

`ifdef M_DIV_REM_FUSE_EN
  logic            fz_v_q, fz_v_d, fz_sgn_q, fz_sgn_d;
  logic [XLEN-1:0] fz_rs1_q, fz_rs1_d, fz_rs2_q, fz_rs2_d, fz_quo_q, fz_quo_d, fz_rem_q, fz_rem_d;

  always_comb begin
    fuse_hit = fz_v_q && (rs1 == fz_rs1_q) && (rs2 == fz_rs2_q) && (in_signed == fz_sgn_q);
    fuse_res = in_rem ? fz_rem_q : fz_quo_q;
  end
`else
  always_comb begin
    fuse_hit = 1'b0;
    fuse_res = '0;
  end
`endif

  // Next-state and registered-output logic; flush overrides everything but reset.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;
`ifdef M_DIV_REM_FUSE_EN
    fz_v_d   = fz_v_q;
    fz_sgn_d = fz_sgn_q;
    fz_rs1_d = fz_rs1_q;
    fz_rs2_d = fz_rs2_q;
    fz_quo_d = fz_quo_q;
    fz_rem_d = fz_rem_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_d = in_req;
          if (!in_div) begin
            state_d = ST_MUL;
          end else if (in_div0) begin
            state_d  = ST_DONE;
            result_d = in_rem ? rs1 : '1;
          end else if (in_ovf) begin
            state_d  = ST_DONE;
            result_d = in_rem ? '0 : 32'h8000_0000;
          end else if (fuse_hit) begin
            state_d  = ST_DONE;
            result_d = fuse_res;
          end else begin
            state_d = ST_DIV;
            cnt_d   = CNT_LOAD;
            rem_d   = '0;
            quo_d   = mag(rs1, in_signed);
            dvs_d   = mag(rs2, in_signed);
          end
        end
      end
      ST_MUL: begin
        state_d  = ST_DONE;
        result_d = mul_res;
      end
      ST_DIV: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d  = ST_DONE;
          result_d = div_res;
`ifdef M_DIV_REM_FUSE_EN
          fz_v_d   = 1'b1;
          fz_sgn_d = req_q.is_signed;
          fz_rs1_d = req_q.rs1;
          fz_rs2_d = req_q.rs2;
          fz_quo_d = quo_fix;
          fz_rem_d = rem_fix;
`endif
        end
      end
      ST_DONE: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
`ifdef M_DIV_REM_FUSE_EN
      fz_v_d  = 1'b0;
`endif
    end
    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_DONE);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      cnt_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      dvs_q        <= '0;
      result_q     <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef M_DIV_REM_FUSE_EN
      fz_v_q       <= 1'b0;
      fz_sgn_q     <= 1'b0;
      fz_rs1_q     <= '0;
      fz_rs2_q     <= '0;
      fz_quo_q     <= '0;
      fz_rem_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      dvs_q        <= dvs_d;
      result_q     <= result_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
`ifdef M_DIV_REM_FUSE_EN
      fz_v_q       <= fz_v_d;
      fz_sgn_q     <= fz_sgn_d;
      fz_rs1_q     <= fz_rs1_d;
      fz_rs2_q     <= fz_rs2_d;
      fz_quo_q     <= fz_quo_d;
      fz_rem_q     <= fz_rem_d;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign result     = result_q;
  assign busy       = busy_q;

endmodule
